pool_mem_arbiter: RTL

- Sequences and shares the dual-port pool memory of one conv layer between two requesters: the layer's pool writer (producer) and the next layer's feature reader (consumer).
- Drives the layer-side `*_use_out` address/rden/wren bus that feeds the pool memory instances.
- Owns layer start/handoff: enables the producing layer, waits for pool_done, drains, then grants the memory to the consumer until cons_done.

---
 rtl/pool_mem_arbiter_if.sv | 49 ++++
 rtl/pool_mem_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pool_mem_arbiter_if.sv
// Bus bundle between the pool memory arbiter and its requesters / pool memory.
// master = requester/memory side, slave = arbiter side.
interface pool_mem_arbiter_if #(
  parameter int POOL_ADDR_WIDTH = 10,
  parameter int FRAME_CNT_WIDTH = 8
);
  logic                       enable;
  logic [POOL_ADDR_WIDTH-1:0] prod_address_a;
  logic [POOL_ADDR_WIDTH-1:0] prod_address_b;
  logic                       prod_rden_a;
  logic                       prod_rden_b;
  logic                       prod_wren_a;
  logic                       prod_wren_b;
  logic                       pool_done;
  logic [POOL_ADDR_WIDTH-1:0] cons_address_a;
  logic [POOL_ADDR_WIDTH-1:0] cons_address_b;
  logic                       cons_rden_a;
  logic                       cons_rden_b;
  logic                       cons_done;
  logic [POOL_ADDR_WIDTH-1:0] address_a_t_use_out;
  logic [POOL_ADDR_WIDTH-1:0] address_b_t_use_out;
  logic                       rden_a_use_out;
  logic                       rden_b_use_out;
  logic                       wren_a_use_out;
  logic                       wren_b_use_out;
  logic                       layer_enable;
  logic                       next_enable;
  logic [1:0]                 owner;
  logic [FRAME_CNT_WIDTH-1:0] frame_count;
  logic                       conflict_err;

  modport master (
    output enable, prod_address_a, prod_address_b, prod_rden_a, prod_rden_b,
           prod_wren_a, prod_wren_b, pool_done, cons_address_a, cons_address_b,
           cons_rden_a, cons_rden_b, cons_done,
    input  address_a_t_use_out, address_b_t_use_out, rden_a_use_out, rden_b_use_out,
           wren_a_use_out, wren_b_use_out, layer_enable, next_enable, owner,
           frame_count, conflict_err
  );

  modport slave (
    input  enable, prod_address_a, prod_address_b, prod_rden_a, prod_rden_b,
           prod_wren_a, prod_wren_b, pool_done, cons_address_a, cons_address_b,
           cons_rden_a, cons_rden_b, cons_done,
    output address_a_t_use_out, address_b_t_use_out, rden_a_use_out, rden_b_use_out,
           wren_a_use_out, wren_b_use_out, layer_enable, next_enable, owner,
           frame_count, conflict_err
  );
endinterface

// File: rtl/pool_mem_arbiter.sv
// Shares one conv layer's pool memory between its pool writer and the next layer's reader.
// Define POOL_ARB_ERRCHK_EN to build the sticky access-violation checker (conflict_err).
//
// state   | meaning
// IDLE    | no owner, waiting for enable
// PRODUCE | producing layer enabled and owns the memory
// DRAIN   | nobody owns the memory for HANDOFF_CYCLES cycles
// CONSUME | consuming layer enabled, read-only access
module pool_mem_arbiter #(
  parameter int POOL_ADDR_WIDTH = 10,
  parameter int HANDOFF_CYCLES  = 2,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input logic clock,
  input logic reset,
  pool_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(HANDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(HANDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRODUCE = 2'd1, DRAIN = 2'd2, CONSUME = 2'd3} state_t;

  state_t                     state, next_state;
  logic [CNT_W-1:0]           drain_cnt;
  logic [POOL_ADDR_WIDTH-1:0] addr_a, addr_b;
  logic                       rden_a, rden_b, wren_a, wren_b;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
  logic [1:0]                 owner;
  logic                       layer_en, next_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.enable)       next_state = PRODUCE;
      PRODUCE: if (bus.pool_done)    next_state = DRAIN;
      DRAIN:   if (drain_cnt == '0)  next_state = CONSUME;
      CONSUME: if (bus.cons_done)    next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  always_comb begin
    owner    = 2'd0;
    layer_en = 1'b0;
    next_en  = 1'b0;
    case (state)
      PRODUCE: begin owner = 2'd1; layer_en = 1'b1; end
      CONSUME: begin owner = 2'd2; next_en  = 1'b1; end
      default: ;
    endcase
  end

  // Down-counter loaded on the pool_done edge; DRAIN exits at terminal count zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                drain_cnt <= '0;
    else if (state == PRODUCE && bus.pool_done) drain_cnt <= DRAIN_LOAD;
    else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - CNT_W'(1);
  end

  // Gate by next_state so the strobes always agree with owner on the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_a <= '0;
      addr_b <= '0;
      rden_a <= 1'b0;
      rden_b <= 1'b0;
      wren_a <= 1'b0;
      wren_b <= 1'b0;
    end else begin
      case (next_state)
        PRODUCE: begin
          addr_a <= bus.prod_address_a;
          addr_b <= bus.prod_address_b;
          rden_a <= bus.prod_rden_a;
          rden_b <= bus.prod_rden_b;
          wren_a <= bus.prod_wren_a;
          wren_b <= bus.prod_wren_b;
        end
        CONSUME: begin
          addr_a <= bus.cons_address_a;
          addr_b <= bus.cons_address_b;
          rden_a <= bus.cons_rden_a;
          rden_b <= bus.cons_rden_b;
          wren_a <= 1'b0;
          wren_b <= 1'b0;
        end
        default: begin
          rden_a <= 1'b0;
          rden_b <= 1'b0;
          wren_a <= 1'b0;
          wren_b <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 frame_cnt <= '0;
    else if (state == CONSUME && bus.cons_done) frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
  end

`ifdef POOL_ARB_ERRCHK_EN
  logic err_hit, err_q;

  assign err_hit = ((bus.prod_wren_a || bus.prod_wren_b) && state != PRODUCE) ||
                   ((bus.cons_rden_a || bus.cons_rden_b) && state != CONSUME) ||
                   (state == PRODUCE && bus.prod_wren_a && bus.prod_wren_b &&
                    bus.prod_address_a == bus.prod_address_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign bus.conflict_err = err_q;
`else
  assign bus.conflict_err = 1'b0;
`endif

  assign bus.address_a_t_use_out = addr_a;
  assign bus.address_b_t_use_out = addr_b;
  assign bus.rden_a_use_out      = rden_a;
  assign bus.rden_b_use_out      = rden_b;
  assign bus.wren_a_use_out      = wren_a;
  assign bus.wren_b_use_out      = wren_b;
  assign bus.owner               = owner;
  assign bus.layer_enable        = layer_en;
  assign bus.next_enable         = next_en;
  assign bus.frame_count         = frame_cnt;
endmodule
